// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder: group width,
// the 4-bit lookahead equations and the per-stage pipeline record.
package cla_pkg;

    localparam int GROUP_W = 4;
    localparam int MAX_W   = 64;

    typedef struct packed {
        logic [GROUP_W-1:0] s;
        logic               co;
        logic               c3;
    } grp_res_t;

    // Operand and sum fields are sized for the widest supported adder.
    typedef struct packed {
        logic             valid;
        logic [MAX_W-1:0] a_hi;
        logic [MAX_W-1:0] b_hi;
        logic [MAX_W-1:0] sum_lo;
        logic             carry;
    } stage_t;

    function automatic grp_res_t cla4(input logic [GROUP_W-1:0] a,
                                      input logic [GROUP_W-1:0] b,
                                      input logic               ci);
        logic [GROUP_W-1:0] g;
        logic [GROUP_W-1:0] p;
        logic [GROUP_W:0]   c;
        grp_res_t           r;
        g    = a & b;
        p    = a ^ b;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        r.s  = p ^ c[GROUP_W-1:0];
        r.co = c[4];
        r.c3 = c[3];
        return r;
    endfunction

endpackage

// File: rtl/cla_group4.sv
// Combinational 4-bit carry-lookahead group; c3 is the carry into the group MSB.
module cla_group4
    import cla_pkg::*;
(
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    input  logic               ci,
    output logic [GROUP_W-1:0] s,
    output logic               co,
    output logic               c3
);

    grp_res_t res;

    assign res = cla4(a, b, ci);
    assign s   = res.s;
    assign co  = res.co;
    assign c3  = res.c3;

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead add/subtract: one 4-bit group per stage, the group
// carry rippling through registers, with a global valid/ready stall.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NG = WIDTH / GROUP_W;

    logic               stall;
    logic               accept;
    logic [WIDTH-1:0]   b_eff;
    stage_t             in_rec;
    stage_t             stage_p [NG];
    logic [GROUP_W-1:0] grp_s   [NG];
    logic               grp_co  [NG];
    logic               grp_c3  [NG];

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign accept   = in_valid & in_ready;

    // Subtraction is folded into the operands once, at accept.
    assign b_eff         = sub ? ~b : b;
    assign in_rec.valid  = accept;
    assign in_rec.a_hi   = MAX_W'(a);
    assign in_rec.b_hi   = MAX_W'(b_eff);
    assign in_rec.sum_lo = '0;
    assign in_rec.carry  = cin ^ sub;

    for (genvar k = 0; k < NG; k++) begin : g_grp
        cla_group4 u_grp (
            .a  (stage_p[k].a_hi[GROUP_W*k +: GROUP_W]),
            .b  (stage_p[k].b_hi[GROUP_W*k +: GROUP_W]),
            .ci (stage_p[k].carry),
            .s  (grp_s[k]),
            .co (grp_co[k]),
            .c3 (grp_c3[k])
        );
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NG; k++) begin
                stage_p[k] <= '0;
            end
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (!stall) begin
            // Stage 0 captures the transformed operands; stage k holds group k-1 done.
            stage_p[0] <= in_rec;
            for (int k = 1; k < NG; k++) begin
                stage_p[k]                                   <= stage_p[k-1];
                stage_p[k].sum_lo[GROUP_W*(k-1) +: GROUP_W] <= grp_s[k-1];
                stage_p[k].carry                             <= grp_co[k-1];
            end
            // Output register: results only change when a real beat completes.
            out_valid <= stage_p[NG-1].valid;
            if (stage_p[NG-1].valid) begin
                sum                      <= stage_p[NG-1].sum_lo[WIDTH-1:0];
                sum[WIDTH-1 -: GROUP_W]  <= grp_s[NG-1];
                cout                     <= grp_co[NG-1];
                ovf                      <= grp_c3[NG-1] ^ grp_co[NG-1];
            end
        end
    end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder (WIDTH=16): directed vectors, stall,
// mid-flight reset and throttled random traffic.
module tb_cla_pipe_adder;

    localparam int WIDTH = 16;
    localparam int NG    = WIDTH / 4;

    logic             CLK = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    cla_pipe_adder #(.WIDTH(WIDTH)) dut (
        .CLK       (CLK),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        logic             chk_lat;
        logic [31:0]      cyc;
    } exp_t;

    exp_t        sb[$];
    int          passed = 0;
    int          total  = 0;
    int unsigned cyc    = 0;
    bit          rand_mode = 1'b0;
    bit          count_low = 1'b0;
    int          low_cnt   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    // Reference arithmetic, independent of the lookahead structure.
    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic ci, input logic s);
        exp_t        m;
        logic [16:0] r;
        int          sv;
        m = '0;
        if (!s) begin
            r      = {1'b0, x} + {1'b0, y} + 17'(ci);
            m.cout = r[16];
            sv     = int'($signed(x)) + int'($signed(y)) + int'(ci);
        end else begin
            r      = {1'b0, x} - {1'b0, y} - 17'(ci);
            m.cout = ~r[16];
            sv     = int'($signed(x)) - int'($signed(y)) - int'(ci);
        end
        m.sum = r[15:0];
        m.ovf = (sv > 32767) || (sv < -32768);
        return m;
    endfunction

    always @(posedge CLK) cyc++;

    // Monitor: pops the scoreboard whenever the DUT hands over a result.
    always @(negedge CLK) begin
        exp_t e;
        if (count_low && !in_ready) low_cnt++;
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", {47'd0, ovf, cout, sum}, 64'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("sum", 64'(sum), 64'(e.sum));
                check("cout", 64'(cout), 64'(e.cout));
                check("ovf", 64'(ovf), 64'(e.ovf));
                if (e.chk_lat) check("latency", 64'(cyc - e.cyc), 64'(NG));
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                        input logic tcin, input logic tsub,
                        input logic [WIDTH-1:0] es, input logic ec, input logic eo,
                        input logic lat);
        int   n;
        exp_t e;
        n = 0;
        a = ta; b = tb_; cin = tcin; sub = tsub; in_valid = 1'b1;
        @(negedge CLK);
        while (!in_ready) begin
            n++;
            if (n > 200) begin
                check("in_ready_timeout", 64'(in_ready), 64'd1);
                break;
            end
            @(negedge CLK);
        end
        e.sum = es; e.cout = ec; e.ovf = eo; e.chk_lat = lat; e.cyc = cyc + 1;
        sb.push_back(e);
        @(posedge CLK); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_model(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                              input logic tcin, input logic tsub);
        exp_t m;
        m = model(ta, tb_, tcin, tsub);
        send(ta, tb_, tcin, tsub, m.sum, m.cout, m.ovf, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        idle(2);
        @(negedge CLK);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_outputs", {47'd0, ovf, cout, sum}, 64'd0);
        @(posedge CLK); #1;
        reset = 1'b0;
        idle(1);

        // Directed corner vectors, each measured for latency.
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        idle(NG + 2);
        send(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1);
        send(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b1);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
        send(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b1);
        send(16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0, 1'b1);
        send(16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1);
        idle(NG + 3);
        check("directed_drained", 64'(sb.size()), 64'd0);

        // Eight back-to-back beats with a three-cycle consumer stall.
        low_cnt = 0; count_low = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(16'(i * 16'h1111), 16'h0001, 1'b0, 1'b0,
                         16'(i * 16'h1111 + 1), 1'b0, 1'b0, 1'b0);
                end
            end
            begin
                idle(6);
                out_ready = 1'b0;
                idle(3);
                out_ready = 1'b1;
            end
        join
        idle(NG + 4);
        count_low = 1'b0;
        check("stall_in_ready_low_cycles", 64'(low_cnt), 64'd3);
        check("stall_drained", 64'(sb.size()), 64'd0);

        // Reset while three beats are in flight: none may ever appear.
        send(16'hAAAA, 16'h1111, 1'b0, 1'b0, 16'hBBBB, 1'b0, 1'b0, 1'b0);
        send(16'h0101, 16'h0202, 1'b0, 1'b0, 16'h0303, 1'b0, 1'b0, 1'b0);
        send(16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        sb.delete();
        #1;
        check("async_reset_out_valid", 64'(out_valid), 64'd0);
        @(negedge CLK);
        check("reset_hold_out_valid", 64'(out_valid), 64'd0);
        idle(2);
        reset = 1'b0;
        send(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b1);
        idle(NG + 6);
        check("post_reset_drained", 64'(sb.size()), 64'd0);

        // Throttled random traffic against the reference model.
        rand_mode = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            send_model(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        end
        rand_mode = 1'b0;
        #2;
        out_ready = 1'b1;
        idle(NG + 10);
        check("random_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        while (1) begin
            @(posedge CLK); #1;
            if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1);
    end

endmodule
